// File: rtl/fu_scalar_lsq_if.sv
// Issue-side request/response and data-memory handshake bundle for fu_scalar_lsq.
// master = issue stage plus memory model, slave = the load/store unit.
interface fu_scalar_lsq_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int TAG_W  = 4
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_store;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_W-1:0]     rs1;
  logic [ADDR_W-1:0]     imm;
  logic [DATA_W-1:0]     rs2;
  logic [TAG_W-1:0]      req_tag;
  logic                  flush;
  logic                  dmemREN;
  logic                  dmemWEN;
  logic [ADDR_W-1:0]     dmemaddr;
  logic [DATA_W-1:0]     dmemstore;
  logic [DATA_W/8-1:0]   dmembyteen;
  logic                  dhit_in;
  logic [DATA_W-1:0]     dmem_in;
  logic                  resp_valid;
  logic [TAG_W-1:0]      resp_tag;
  logic [DATA_W-1:0]     resp_data;
  logic                  resp_fault;

  modport master (
    output req_valid, req_store, req_size, req_unsigned, rs1, imm, rs2, req_tag, flush,
    output dhit_in, dmem_in,
    input  req_ready, dmemREN, dmemWEN, dmemaddr, dmemstore, dmembyteen,
    input  resp_valid, resp_tag, resp_data, resp_fault
  );

  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, rs1, imm, rs2, req_tag, flush,
    input  dhit_in, dmem_in,
    output req_ready, dmemREN, dmemWEN, dmemaddr, dmemstore, dmembyteen,
    output resp_valid, resp_tag, resp_data, resp_fault
  );
endinterface

// File: rtl/fu_scalar_lsq.sv
// In-order scalar load/store unit: DEPTH-entry request queue, one dmem access at a time, tagged response
// one cycle after dhit_in (faults answer one cycle after reaching the head); req_ready drops when full or flushing.
module fu_scalar_lsq #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 4
) (
  input logic             i_clk,
  input logic             i_rst,
  fu_scalar_lsq_if.slave  bus
);
  localparam int BYTES = DATA_W / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdat;
    logic              store;
    logic [1:0]        size;
    logic              uns;
    logic [TAG_W-1:0]  tag;
  } entry_t;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  entry_t            r_q [DEPTH];
  logic [PW-1:0]     r_rd_ptr;
  logic [PW-1:0]     r_wr_ptr;
  logic [CW-1:0]     r_count;
  logic              r_resp_vld;
  logic [TAG_W-1:0]  r_resp_tag;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_fault;

  entry_t            w_head;
  entry_t            w_new;
  logic              w_full;
  logic              w_empty;
  logic              w_enq;
  logic              w_deq;
  logic              w_ren;
  logic              w_wen;
  logic              w_resp_set;
  logic              w_resp_fault;
  logic              w_fault;
  logic [LB-1:0]     w_lane;
  int                w_nbytes;
  logic [BYTES-1:0]  w_be;
  logic [DATA_W-1:0] w_st;
  logic [DATA_W-1:0] w_shift;
  logic [DATA_W-1:0] w_ld;
  logic              w_sign;

  assign w_head  = r_q[r_rd_ptr];
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign bus.req_ready = !w_full && !bus.flush;
  assign w_enq   = bus.req_valid && bus.req_ready;

  assign w_new.addr  = bus.rs1 + bus.imm;
  assign w_new.wdat  = bus.rs2;
  assign w_new.store = bus.req_store;
  assign w_new.size  = bus.req_size;
  assign w_new.uns   = bus.req_unsigned;
  assign w_new.tag   = bus.req_tag;

  // Head decode: alignment, lane mask, replicated store data and extended load data.
  always_comb begin
    w_nbytes = 1 << w_head.size;
    w_lane   = w_head.addr[LB-1:0];
    w_fault  = (w_nbytes > BYTES) || ((w_head.addr[2:0] & 3'(w_nbytes - 1)) != 3'd0);
    w_be     = '0;
    w_st     = '0;
    for (int b = 0; b < BYTES; b++) begin
      w_be[b]        = (b >= int'(w_lane)) && (b < int'(w_lane) + w_nbytes);
      w_st[8*b +: 8] = w_head.wdat[8*(b & (w_nbytes - 1)) +: 8];
    end
    w_shift = bus.dmem_in >> {w_lane, 3'b000};
    w_sign  = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i == 8*w_nbytes - 1) w_sign = w_shift[i];
    end
    w_ld = '0;
    for (int i = 0; i < DATA_W; i++) begin
      w_ld[i] = (i < 8*w_nbytes) ? w_shift[i] : (w_sign && !w_head.uns);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_deq        = 1'b0;
    w_ren        = 1'b0;
    w_wen        = 1'b0;
    w_resp_set   = 1'b0;
    w_resp_fault = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty && !bus.flush) begin
          if (w_fault) begin
            w_deq        = 1'b1;
            w_resp_set   = 1'b1;
            w_resp_fault = 1'b1;
          end else begin
            w_state_nxt = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        w_ren = !w_head.store && !bus.dhit_in;
        w_wen =  w_head.store && !bus.dhit_in;
        if (bus.dhit_in) begin
          w_deq       = 1'b1;
          w_resp_set  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_enq) r_q[r_wr_ptr] <= w_new;
  end

  // Flush keeps only an in-flight head; in IDLE nothing is in flight so the queue empties.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (bus.flush) begin
      if (r_state == S_ACCESS) begin
        r_rd_ptr <= r_rd_ptr + PW'(w_deq);
        r_wr_ptr <= r_rd_ptr + PW'(1);
        r_count  <= w_deq ? CW'(0) : CW'(1);
      end else begin
        r_wr_ptr <= r_rd_ptr;
        r_count  <= '0;
      end
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_enq) - CW'(w_deq);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_resp_vld   <= 1'b0;
      r_resp_tag   <= '0;
      r_resp_data  <= '0;
      r_resp_fault <= 1'b0;
    end else begin
      r_resp_vld <= w_resp_set;
      if (w_resp_set) begin
        r_resp_tag   <= w_head.tag;
        r_resp_fault <= w_resp_fault;
        r_resp_data  <= (w_resp_fault || w_head.store) ? '0 : w_ld;
      end
    end
  end

  assign bus.dmemREN    = w_ren;
  assign bus.dmemWEN    = w_wen;
  assign bus.dmemaddr   = (r_state == S_ACCESS) ? {w_head.addr[ADDR_W-1:LB], LB'(0)} : '0;
  assign bus.dmemstore  = (r_state == S_ACCESS) ? w_st : '0;
  assign bus.dmembyteen = (r_state == S_ACCESS) ? w_be : '0;
  assign bus.resp_valid = r_resp_vld;
  assign bus.resp_tag   = r_resp_tag;
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_fault = r_resp_fault;
endmodule

// File: tb/tb_fu_scalar_lsq.sv
// Directed bench for fu_scalar_lsq: a vector table of single transactions plus
// hand-written sequences for hold, ordering, full, flush and reset corners.
module tb_fu_scalar_lsq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  fu_scalar_lsq_if #(.DATA_W(32), .ADDR_W(32), .TAG_W(4)) bus_if ();

  fu_scalar_lsq #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .TAG_W(4)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus_if)
  );

  typedef struct {
    logic        store;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] rs1;
    logic [31:0] imm;
    logic [31:0] rs2;
    logic [31:0] mem;
    logic        fault;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mst;
    logic [31:0] data;
  } vec_t;

  vec_t vt [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_req(input logic st, input logic [1:0] sz, input logic un,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] d, input logic [3:0] tg);
    bus_if.req_valid    = 1'b1;
    bus_if.req_store    = st;
    bus_if.req_size     = sz;
    bus_if.req_unsigned = un;
    bus_if.rs1          = a;
    bus_if.imm          = b;
    bus_if.rs2          = d;
    bus_if.req_tag      = tg;
  endtask

  task automatic serve_one(input logic [3:0] tg, input logic [31:0] md);
    int k;
    k = 0;
    while (!bus_if.dmemREN && k < 20) begin
      step();
      k++;
    end
    chk("serve_wait_strobe", {63'd0, bus_if.dmemREN}, 64'd1);
    bus_if.dhit_in = 1'b1;
    bus_if.dmem_in = md;
    step();
    bus_if.dhit_in = 1'b0;
    settle();
    chk("serve_resp_valid", {63'd0, bus_if.resp_valid}, 64'd1);
    chk("serve_resp_tag", {60'd0, bus_if.resp_tag}, {60'd0, tg});
  endtask

  initial begin
    bus_if.req_valid = 1'b0;
    bus_if.req_store = 1'b0;
    bus_if.req_size = 2'd0;
    bus_if.req_unsigned = 1'b0;
    bus_if.rs1 = '0;
    bus_if.imm = '0;
    bus_if.rs2 = '0;
    bus_if.req_tag = '0;
    bus_if.flush = 1'b0;
    bus_if.dhit_in = 1'b0;
    bus_if.dmem_in = '0;

    vt[0]  = '{1'b0, 2'd2, 1'b0, 32'h100, 32'h4, 32'h0, 32'hDEADBEEF, 1'b0, 4'b1111, 32'h104, 32'h0, 32'hDEADBEEF};
    vt[1]  = '{1'b0, 2'd0, 1'b0, 32'h200, 32'h3, 32'h0, 32'h80123456, 1'b0, 4'b1000, 32'h200, 32'h0, 32'hFFFFFF80};
    vt[2]  = '{1'b0, 2'd0, 1'b1, 32'h200, 32'h3, 32'h0, 32'h80123456, 1'b0, 4'b1000, 32'h200, 32'h0, 32'h00000080};
    vt[3]  = '{1'b1, 2'd1, 1'b0, 32'h0,   32'h2, 32'h1234ABCD, 32'h0, 1'b0, 4'b1100, 32'h0, 32'hABCDABCD, 32'h0};
    vt[4]  = '{1'b0, 2'd1, 1'b0, 32'h10,  32'h2, 32'h0, 32'h9ABC1234, 1'b0, 4'b1100, 32'h10, 32'h0, 32'hFFFF9ABC};
    vt[5]  = '{1'b1, 2'd0, 1'b0, 32'h100, 32'h1, 32'h000000A5, 32'h0, 1'b0, 4'b0010, 32'h100, 32'hA5A5A5A5, 32'h0};
    vt[6]  = '{1'b0, 2'd1, 1'b0, 32'h100, 32'h1, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0};
    vt[7]  = '{1'b0, 2'd3, 1'b0, 32'h200, 32'h0, 32'h0, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0};
    vt[8]  = '{1'b1, 2'd2, 1'b0, 32'h200, 32'h2, 32'h11223344, 32'h0, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0};
    vt[9]  = '{1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h8, 32'h0, 32'h01020304, 1'b0, 4'b1111, 32'h4, 32'h0, 32'h01020304};
    vt[10] = '{1'b0, 2'd1, 1'b1, 32'h40,  32'h0, 32'h0, 32'hFFFF8001, 1'b0, 4'b0011, 32'h40, 32'h0, 32'h00008001};

    // Reset state
    step();
    step();
    chk("rst_resp_valid", {63'd0, bus_if.resp_valid}, 64'd0);
    chk("rst_resp_tag", {60'd0, bus_if.resp_tag}, 64'd0);
    chk("rst_resp_data", {32'd0, bus_if.resp_data}, 64'd0);
    chk("rst_strobes", {62'd0, bus_if.dmemREN, bus_if.dmemWEN}, 64'd0);
    chk("rst_dmem_bus", {bus_if.dmemaddr, bus_if.dmemstore | {28'd0, bus_if.dmembyteen}}, 64'd0);
    rst = 1'b0;
    settle();
    chk("rst_ready", {63'd0, bus_if.req_ready}, 64'd1);

    for (int i = 0; i < 11; i++) begin
      drive_req(vt[i].store, vt[i].size, vt[i].uns, vt[i].rs1, vt[i].imm, vt[i].rs2, 4'(i));
      settle();
      chk("vec_ready", {63'd0, bus_if.req_ready}, 64'd1);
      step();
      bus_if.req_valid = 1'b0;
      settle();
      chk("vec_idle_strobes", {62'd0, bus_if.dmemREN, bus_if.dmemWEN}, 64'd0);
      step();
      if (vt[i].fault) begin
        chk("vec_fault_valid", {63'd0, bus_if.resp_valid}, 64'd1);
        chk("vec_fault_flag", {63'd0, bus_if.resp_fault}, 64'd1);
        chk("vec_fault_tag", {60'd0, bus_if.resp_tag}, 64'(i));
        chk("vec_fault_data", {32'd0, bus_if.resp_data}, 64'd0);
        chk("vec_fault_nostrobe", {62'd0, bus_if.dmemREN, bus_if.dmemWEN}, 64'd0);
        step();
      end else begin
        chk("vec_strobes", {62'd0, bus_if.dmemREN, bus_if.dmemWEN}, {62'd0, !vt[i].store, vt[i].store});
        chk("vec_addr", {32'd0, bus_if.dmemaddr}, {32'd0, vt[i].maddr});
        chk("vec_byteen", {60'd0, bus_if.dmembyteen}, {60'd0, vt[i].be});
        if (vt[i].store) chk("vec_store_data", {32'd0, bus_if.dmemstore}, {32'd0, vt[i].mst});
        bus_if.dhit_in = 1'b1;
        bus_if.dmem_in = vt[i].mem;
        settle();
        chk("vec_strobe_drop", {62'd0, bus_if.dmemREN, bus_if.dmemWEN}, 64'd0);
        step();
        bus_if.dhit_in = 1'b0;
        settle();
        chk("vec_resp_valid", {63'd0, bus_if.resp_valid}, 64'd1);
        chk("vec_resp_tag", {60'd0, bus_if.resp_tag}, 64'(i));
        chk("vec_resp_data", {32'd0, bus_if.resp_data}, {32'd0, vt[i].data});
        chk("vec_resp_fault", {63'd0, bus_if.resp_fault}, 64'd0);
        step();
        chk("vec_resp_pulse", {63'd0, bus_if.resp_valid}, 64'd0);
      end
    end

    // Half store held for three wait cycles
    drive_req(1'b1, 2'd1, 1'b0, 32'h0, 32'h2, 32'h1234ABCD, 4'd5);
    step();
    bus_if.req_valid = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      chk("hold_wen", {62'd0, bus_if.dmemWEN, bus_if.dmemREN}, 64'd2);
      chk("hold_store", {32'd0, bus_if.dmemstore}, 64'hABCDABCD);
      chk("hold_byteen", {60'd0, bus_if.dmembyteen}, 64'hC);
      chk("hold_noresp", {63'd0, bus_if.resp_valid}, 64'd0);
      step();
    end
    bus_if.dhit_in = 1'b1;
    step();
    bus_if.dhit_in = 1'b0;
    settle();
    chk("hold_resp", {59'd0, bus_if.resp_valid, bus_if.resp_tag}, {59'd0, 1'b1, 4'd5});
    chk("hold_resp_data", {32'd0, bus_if.resp_data}, 64'd0);
    step();

    // Misaligned half then word: fault answered first, then normal access
    drive_req(1'b0, 2'd1, 1'b0, 32'h100, 32'h1, 32'h0, 4'd1);
    step();
    drive_req(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, 32'h0, 4'd2);
    step();
    bus_if.req_valid = 1'b0;
    settle();
    chk("order_fault_resp", {58'd0, bus_if.resp_valid, bus_if.resp_fault, bus_if.resp_tag}, {58'd0, 1'b1, 1'b1, 4'd1});
    chk("order_fault_nostrobe", {63'd0, bus_if.dmemREN}, 64'd0);
    step();
    chk("order_second_ren", {63'd0, bus_if.dmemREN}, 64'd1);
    chk("order_second_addr", {32'd0, bus_if.dmemaddr}, 64'h200);
    serve_one(4'd2, 32'h55);
    chk("order_second_fault", {63'd0, bus_if.resp_fault}, 64'd0);
    step();

    // Queue full, then first dhit_in reopens req_ready
    for (int k = 0; k < 4; k++) begin
      drive_req(1'b0, 2'd2, 1'b0, 32'h400, 32'(4*k), 32'h0, 4'(k));
      settle();
      chk("full_ready_before", {63'd0, bus_if.req_ready}, 64'd1);
      step();
    end
    bus_if.req_valid = 1'b0;
    settle();
    chk("full_ready_low", {63'd0, bus_if.req_ready}, 64'd0);
    chk("full_head_ren", {63'd0, bus_if.dmemREN}, 64'd1);
    bus_if.dhit_in = 1'b1;
    bus_if.dmem_in = 32'hA0;
    step();
    bus_if.dhit_in = 1'b0;
    settle();
    chk("full_ready_back", {63'd0, bus_if.req_ready}, 64'd1);
    chk("full_resp0", {59'd0, bus_if.resp_valid, bus_if.resp_tag}, {59'd0, 1'b1, 4'd0});
    serve_one(4'd1, 32'hA1);
    serve_one(4'd2, 32'hA2);
    serve_one(4'd3, 32'hA3);
    chk("full_resp3_data", {32'd0, bus_if.resp_data}, 64'hA3);
    step();

    // Flush during ACCESS with three queued behind the head
    for (int k = 0; k < 4; k++) begin
      drive_req(1'b0, 2'd2, 1'b0, 32'h500, 32'(4*k), 32'h0, 4'(8 + k));
      step();
    end
    bus_if.req_valid = 1'b0;
    bus_if.flush = 1'b1;
    settle();
    chk("flush_ready_low", {63'd0, bus_if.req_ready}, 64'd0);
    step();
    bus_if.flush = 1'b0;
    settle();
    chk("flush_head_held", {63'd0, bus_if.dmemREN}, 64'd1);
    chk("flush_head_addr", {32'd0, bus_if.dmemaddr}, 64'h500);
    serve_one(4'd8, 32'hB0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("flush_empty_quiet", {62'd0, bus_if.dmemREN, bus_if.resp_valid}, 64'd0);
    end

    // Flush in IDLE suppresses a pending fault
    drive_req(1'b0, 2'd2, 1'b0, 32'h600, 32'h1, 32'h0, 4'd7);
    step();
    bus_if.req_valid = 1'b0;
    bus_if.flush = 1'b1;
    step();
    bus_if.flush = 1'b0;
    settle();
    chk("flush_idle_nofault", {63'd0, bus_if.resp_valid}, 64'd0);
    step();
    chk("flush_idle_quiet", {62'd0, bus_if.resp_valid, bus_if.dmemREN}, 64'd0);

    // Reset mid-access abandons the access
    drive_req(1'b1, 2'd2, 1'b0, 32'h700, 32'h0, 32'hCAFEF00D, 4'd6);
    step();
    bus_if.req_valid = 1'b0;
    step();
    chk("rstmid_wen", {63'd0, bus_if.dmemWEN}, 64'd1);
    rst = 1'b1;
    bus_if.dhit_in = 1'b1;
    step();
    rst = 1'b0;
    bus_if.dhit_in = 1'b0;
    settle();
    chk("rstmid_strobes", {62'd0, bus_if.dmemREN, bus_if.dmemWEN}, 64'd0);
    chk("rstmid_bus", {bus_if.dmemaddr, bus_if.dmemstore}, 64'd0);
    chk("rstmid_noresp", {63'd0, bus_if.resp_valid}, 64'd0);
    step();
    chk("rstmid_quiet", {62'd0, bus_if.resp_valid, bus_if.dmemWEN}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
